// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/state enums and op classification for alu_multicycle
//
// Purpose: shared types for the multi-cycle ALU.
//   alu_op_e     : 4-bit opcode carried on ALUSelect
//   alu_state_e  : top-level FSM state
//   isMultiCycle : true for ops that run on the iterative core
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_MUL     = 4'd2,
    OP_AND     = 4'd3,
    OP_OR      = 4'd4,
    OP_XOR     = 4'd5,
    OP_NOT     = 4'd6,
    OP_SLL     = 4'd7,
    OP_SRL     = 4'd8,
    OP_SRA     = 4'd9,
    OP_MULU    = 4'd10,
    OP_DIV     = 4'd11,
    OP_DIVU    = 4'd12,
    OP_REM     = 4'd13,
    OP_REMU    = 4'd14,
    OP_ILLEGAL = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_ITER = 2'd1,
    ST_DIV_ITER = 2'd2,
    ST_DONE     = 2'd3
  } alu_state_e;

  function automatic logic isMultiCycle(input alu_op_e op);
    return op inside {OP_MUL, OP_MULU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// rtl/alu_iter_core.sv - shared radix-2 shift-add multiplier / restoring divider
//
// Purpose: unsigned iterative datapath used for MUL/MULU/DIV*/REM*.
//   Works on magnitudes only; the caller applies signs.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_start        : load operands and begin W iterations
//   i_mode         : 0 = multiply, 1 = divide
//   i_opa, i_opb   : multiplier/multiplicand or dividend/divisor magnitudes
//   o_done         : high during the final iteration cycle
//   o_res_hi/lo    : value the registers take at the end of this cycle
//                    (multiply: product hi/lo; divide: remainder/quotient)
module alu_iter_core #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_mode,
  input  logic [W-1:0] i_opa,
  input  logic [W-1:0] i_opb,
  output logic         o_done,
  output logic [W-1:0] o_res_hi,
  output logic [W-1:0] o_res_lo
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  // r_hi: product accumulator / partial remainder
  // r_lo: multiplier being shifted out / dividend shifted out, quotient shifted in
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_opb;
  logic          r_mode;
  logic          r_busy;
  logic [CW-1:0] r_cnt;

  logic [W:0]    w_mul_sum;
  logic [W:0]    w_div_shift;
  logic [W:0]    w_div_diff;
  logic [W-1:0]  w_nxt_hi;
  logic [W-1:0]  w_nxt_lo;

  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_div_shift = {r_hi, r_lo[W-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opb};
    w_nxt_hi    = '0;
    w_nxt_lo    = '0;
    if (!r_mode) begin
      // Shift the sum right one bit into the low half as the multiplier leaves it.
      w_nxt_hi = w_mul_sum[W:1];
      w_nxt_lo = {w_mul_sum[0], r_lo[W-1:1]};
    end else if (!w_div_diff[W]) begin
      // No borrow: divisor fits, keep the difference and set the quotient bit.
      w_nxt_hi = w_div_diff[W-1:0];
      w_nxt_lo = {r_lo[W-2:0], 1'b1};
    end else begin
      w_nxt_hi = w_div_shift[W-1:0];
      w_nxt_lo = {r_lo[W-2:0], 1'b0};
    end
  end

  assign o_done   = r_busy && (r_cnt == LAST);
  assign o_res_hi = w_nxt_hi;
  assign o_res_lo = w_nxt_lo;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_opb  <= '0;
      r_mode <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_hi   <= '0;
      r_lo   <= i_opa;
      r_opb  <= i_opb;
      r_mode <= i_mode;
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_hi <= w_nxt_hi;
      r_lo <= w_nxt_lo;
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle integer ALU with valid/ready handshakes
//
// Purpose: single-cycle logic/arith/shift ops plus iterative signed/unsigned
//   multiply, divide and remainder. One op in flight; inReady is high only in IDLE.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   inValid/inReady        : op handshake (accepted when both high)
//   inputA, inputB         : operands
//   ALUSelect              : opcode (alu_op_e); nonzero bits above [3:0] decode as illegal
//   outValid/outReady      : result handshake
//   dataOut, dataOutHigh   : primary / secondary result
//   divByZero              : divide-class op had B == 0
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int dataWidth   = 32,
  parameter int selectWidth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [dataWidth-1:0]   inputA,
  input  logic [dataWidth-1:0]   inputB,
  input  logic [selectWidth-1:0] ALUSelect,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [dataWidth-1:0]   dataOut,
  output logic [dataWidth-1:0]   dataOutHigh,
  output logic                   divByZero
);

  localparam int shiftWidth = $clog2(dataWidth);

  alu_state_e           r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [dataWidth-1:0] r_data_out;
  logic [dataWidth-1:0] r_data_out_high;
  logic                 r_div_by_zero;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic                 r_is_rem;
  logic                 r_b_zero;

  alu_op_e               w_op;
  logic                  w_signed_op;
  logic                  w_sign_a;
  logic                  w_sign_b;
  logic [dataWidth-1:0]  w_mag_a;
  logic [dataWidth-1:0]  w_mag_b;
  logic [shiftWidth-1:0] w_shamt;
  logic [dataWidth-1:0]  w_single_res;
  logic                  w_core_start;
  logic                  w_core_mode;
  logic                  w_core_done;
  logic [dataWidth-1:0]  w_core_hi;
  logic [dataWidth-1:0]  w_core_lo;
  logic [2*dataWidth-1:0] w_prod;
  logic [2*dataWidth-1:0] w_prod_fix;
  logic [dataWidth-1:0]  w_quo_fix;
  logic [dataWidth-1:0]  w_rem_fix;

  assign inReady     = r_in_ready;
  assign outValid    = r_out_valid;
  assign dataOut     = r_data_out;
  assign dataOutHigh = r_data_out_high;
  assign divByZero   = r_div_by_zero;

  // Opcode bits above the enum width must be zero for a legal op.
  assign w_op = ((ALUSelect >> 4) != '0) ? OP_ILLEGAL : alu_op_e'(ALUSelect[3:0]);

  assign w_signed_op = (w_op == OP_MUL) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_sign_a    = w_signed_op && inputA[dataWidth-1];
  assign w_sign_b    = w_signed_op && inputB[dataWidth-1];
  // Most-negative operand negates to itself, which is the correct unsigned magnitude.
  assign w_mag_a     = w_sign_a ? -inputA : inputA;
  assign w_mag_b     = w_sign_b ? -inputB : inputB;
  assign w_shamt     = inputB[shiftWidth-1:0];

  assign w_core_start = (r_state == ST_IDLE) && inValid && isMultiCycle(w_op);
  assign w_core_mode  = !((w_op == OP_MUL) || (w_op == OP_MULU));

  always_comb begin
    w_single_res = '0;
    case (w_op)
      OP_ADD: w_single_res = inputA + inputB;
      OP_SUB: w_single_res = inputA - inputB;
      OP_AND: w_single_res = inputA & inputB;
      OP_OR:  w_single_res = inputA | inputB;
      OP_XOR: w_single_res = inputA ^ inputB;
      OP_NOT: w_single_res = ~inputA;
      OP_SLL: w_single_res = inputA << w_shamt;
      OP_SRL: w_single_res = inputA >> w_shamt;
      OP_SRA: w_single_res = $signed(inputA) >>> w_shamt;
      default: w_single_res = '0;
    endcase
  end

  alu_iter_core #(
    .W(dataWidth)
  ) u_iter_core (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (w_core_start),
    .i_mode   (w_core_mode),
    .i_opa    (w_mag_a),
    .i_opb    (w_mag_b),
    .o_done   (w_core_done),
    .o_res_hi (w_core_hi),
    .o_res_lo (w_core_lo)
  );

  // Sign fix-up applied to the core's final-cycle value as it is registered.
  // Overflow (most-negative / -1) falls out naturally: magnitude quotient is
  // 2^(W-1), and negating it yields the same bit pattern.
  assign w_prod     = {w_core_hi, w_core_lo};
  assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
  assign w_quo_fix  = r_b_zero ? '1 : ((r_sign_a ^ r_sign_b) ? -w_core_lo : w_core_lo);
  // With B == 0 the magnitude remainder is |A|, so this restores A itself.
  assign w_rem_fix  = r_sign_a ? -w_core_hi : w_core_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_in_ready      <= 1'b1;
      r_out_valid     <= 1'b0;
      r_data_out      <= '0;
      r_data_out_high <= '0;
      r_div_by_zero   <= 1'b0;
      r_sign_a        <= 1'b0;
      r_sign_b        <= 1'b0;
      r_is_rem        <= 1'b0;
      r_b_zero        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inValid) begin
            r_in_ready <= 1'b0;
            r_sign_a   <= w_sign_a;
            r_sign_b   <= w_sign_b;
            r_is_rem   <= (w_op == OP_REM) || (w_op == OP_REMU);
            r_b_zero   <= (inputB == '0);
            if (isMultiCycle(w_op)) begin
              r_state <= w_core_mode ? ST_DIV_ITER : ST_MUL_ITER;
            end else begin
              r_state         <= ST_DONE;
              r_out_valid     <= 1'b1;
              r_data_out      <= w_single_res;
              r_data_out_high <= '0;
              r_div_by_zero   <= 1'b0;
            end
          end
        end
        ST_MUL_ITER: begin
          if (w_core_done) begin
            r_state         <= ST_DONE;
            r_out_valid     <= 1'b1;
            r_data_out      <= w_prod_fix[dataWidth-1:0];
            r_data_out_high <= w_prod_fix[2*dataWidth-1:dataWidth];
            r_div_by_zero   <= 1'b0;
          end
        end
        ST_DIV_ITER: begin
          if (w_core_done) begin
            r_state         <= ST_DONE;
            r_out_valid     <= 1'b1;
            r_data_out      <= r_is_rem ? w_rem_fix : w_quo_fix;
            r_data_out_high <= r_is_rem ? w_quo_fix : w_rem_fix;
            r_div_by_zero   <= r_b_zero;
          end
        end
        ST_DONE: begin
          if (outReady) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle
module tb_alu_multicycle;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic [3:0]  ALUSelect;
  logic        outValid;
  logic        outReady;
  logic [31:0] dataOut;
  logic [31:0] dataOutHigh;
  logic        divByZero;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_multicycle #(
    .dataWidth  (32),
    .selectWidth(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inValid    (inValid),
    .inReady    (inReady),
    .inputA     (inputA),
    .inputB     (inputB),
    .ALUSelect  (ALUSelect),
    .outValid   (outValid),
    .outReady   (outReady),
    .dataOut    (dataOut),
    .dataOutHigh(dataOutHigh),
    .divByZero  (divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] op);
    return op inside {4'd2, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
  endfunction

  // Reference model: plain arithmetic on the architectural definition.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi, output logic dbz);
    longint          sp;
    longint unsigned up;
    longint unsigned ua;
    longint unsigned ub;
    int              sa;
    int              sb;
    logic [31:0]     q;
    logic [31:0]     r;
    lo  = '0;
    hi  = '0;
    dbz = 1'b0;
    q   = '0;
    r   = '0;
    sa  = $signed(a);
    sb  = $signed(b);
    case (op)
      4'd0:  lo = a + b;
      4'd1:  lo = a - b;
      4'd2: begin
        sp = longint'(sa) * longint'(sb);
        {hi, lo} = sp;
      end
      4'd3:  lo = a & b;
      4'd4:  lo = a | b;
      4'd5:  lo = a ^ b;
      4'd6:  lo = ~a;
      4'd7:  lo = a << b[4:0];
      4'd8:  lo = a >> b[4:0];
      4'd9:  lo = $signed(a) >>> b[4:0];
      4'd10: begin
        ua = a;
        ub = b;
        up = ua * ub;
        {hi, lo} = up;
      end
      4'd11, 4'd12, 4'd13, 4'd14: begin
        if (b == 0) begin
          q   = 32'hFFFF_FFFF;
          r   = a;
          dbz = 1'b1;
        end else if (op == 4'd11 || op == 4'd13) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 0;
          end else begin
            q = sa / sb;
            r = sa % sb;
          end
        end else begin
          q = a / b;
          r = a % b;
        end
        if (op == 4'd11 || op == 4'd12) begin
          lo = q;
          hi = r;
        end else begin
          lo = r;
          hi = q;
        end
      end
      default: lo = '0;
    endcase
  endfunction

  // Issue one op with outReady held high, check latency and results, then the return to IDLE.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] elo;
    logic [31:0] ehi;
    logic        edbz;
    int          lat;
    model(op, a, b, elo, ehi, edbz);
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(inReady), 64'd1);
    inValid   = 1'b1;
    ALUSelect = op;
    inputA    = a;
    inputB    = b;
    outReady  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid   = 1'b0;
    inputA    = $urandom;
    inputB    = $urandom;
    ALUSelect = 4'($urandom);
    lat = 1;
    while (!outValid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), is_multi(op) ? 64'd33 : 64'd1);
    check({tag, ".lo"}, 64'(dataOut), 64'(elo));
    check({tag, ".hi"}, 64'(dataOutHigh), 64'(ehi));
    check({tag, ".dbz"}, 64'(divByZero), 64'(edbz));
    check({tag, ".busy"}, 64'(inReady), 64'd0);
    @(negedge clk);
    check({tag, ".released"}, {62'd0, outValid, inReady}, 64'd1);
  endtask

  logic [31:0] bp_lo;
  logic [31:0] bp_hi;
  logic        bp_dbz;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  int          wait_cnt;

  initial begin
    reset     = 1'b1;
    inValid   = 1'b0;
    inputA    = '0;
    inputB    = '0;
    ALUSelect = '0;
    outReady  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset.in_ready", 64'(inReady), 64'd1);
    check("reset.out_valid", 64'(outValid), 64'd0);
    check("reset.lo", 64'(dataOut), 64'd0);
    check("reset.hi", 64'(dataOutHigh), 64'd0);
    check("reset.dbz", 64'(divByZero), 64'd0);

    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
    run_op("mul_neg", 4'd2, 32'hFFFF_FFFD, 32'd7);
    run_op("mulu_max", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg", 4'd11, 32'hFFFF_FFF9, 32'd2);
    run_op("remu_zero", 4'd14, 32'd7, 32'd0);
    run_op("div_ovf", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_neg_zero", 4'd13, 32'hFFFF_FF00, 32'd0);
    run_op("sra", 4'd9, 32'h8000_00F0, 32'd36);
    run_op("illegal", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0);

    // Backpressure: result must hold and new requests must be ignored.
    model(4'd2, 32'h0001_2345, 32'hFFFF_0003, bp_lo, bp_hi, bp_dbz);
    @(negedge clk);
    inValid   = 1'b1;
    ALUSelect = 4'd2;
    inputA    = 32'h0001_2345;
    inputB    = 32'hFFFF_0003;
    outReady  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    inValid  = 1'b0;
    wait_cnt = 1;
    while (!outValid && wait_cnt < 60) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("bp.latency", 64'(wait_cnt), 64'd33);
    for (int i = 0; i < 5; i++) begin
      inValid   = 1'b1;
      ALUSelect = 4'($urandom_range(0, 1));
      inputA    = $urandom;
      inputB    = $urandom;
      @(negedge clk);
      check("bp.hold_valid", {62'd0, outValid, inReady}, 64'd2);
      check("bp.hold_data", {dataOutHigh, dataOut}, {bp_hi, bp_lo});
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp.to_idle", {62'd0, outValid, inReady}, 64'd1);
    check("bp.data_kept", {dataOutHigh, dataOut}, {bp_hi, bp_lo});

    // Reset in the middle of a divide discards it.
    @(negedge clk);
    inValid   = 1'b1;
    ALUSelect = 4'd11;
    inputA    = 32'hFFFF_FFF9;
    inputB    = 32'd2;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    repeat (10) @(negedge clk);
    check("abort.busy", 64'(inReady), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort.in_ready", 64'(inReady), 64'd1);
    check("abort.out_valid", 64'(outValid), 64'd0);
    check("abort.outs", {dataOutHigh, dataOut}, 64'd0);
    check("abort.dbz", 64'(divByZero), 64'd0);
    repeat (40) @(negedge clk);
    check("abort.no_late_result", {62'd0, outValid, inReady}, 64'd1);
    run_op("after_abort_add", 4'd0, 32'd2, 32'd3);

    for (int n = 0; n < 60; n++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin
          r_a = 32'h8000_0000;
          r_b = 32'hFFFF_FFFF;
        end
        2: r_b = 32'($urandom_range(1, 15));
        3: r_b = -32'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      run_op($sformatf("rand%0d_op%0d", n, r_op), r_op, r_a, r_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
